video_palette: RTL
==================

Name: video_palette

Overview:
- Downstream stage of the layer/sprite composer.
- Takes the composed 8-bit colour index per pixel and looks it up in a 256-entry, 12-bit RGB palette RAM. The RAM is CPU-writable/readable through the register bus.
- Emits registered 4:4:4 RGB with sync/blank delayed to match, feeding the VGA/NTSC output encoders.

Parameters:
- INDEX_BITS, 8, colour index width.
- Derived: palette depth = 2**INDEX_BITS entries; CPU byte address width = INDEX_BITS+1.

Ports:
- clk  in  1  video/system clock
- rst_n  in  1  asynchronous active-low reset
- pal_addr  in  INDEX_BITS+1  CPU byte address; entry = addr[INDEX_BITS:1], addr[0] selects byte
- pal_wrdata  in  8  CPU write data
- pal_write  in  1  CPU write strobe, one cycle per byte
- pal_read  in  1  CPU read strobe
- pal_rddata  out  8  CPU read data, valid the cycle after pal_read
- pix_en  in  1  pixel strobe (qualifies pix_idx/pix_blank/pix_hsync/pix_vsync)
- pix_idx  in  INDEX_BITS  colour index from composer
- pix_blank  in  1  1 = outside visible area
- pix_hsync  in  1  raw hsync, passed through
- pix_vsync  in  1  raw vsync, passed through
- out_en  out  1  output pixel strobe
- out_r  out  4  red
- out_g  out  4  green
- out_b  out  4  blue
- out_blank  out  1  delayed pix_blank
- out_hsync  out  1  delayed pix_hsync
- out_vsync  out  1  delayed pix_vsync

Behaviour:
- Entry format:
  - even byte = {G[3:0], B[3:0]}
  - odd byte = {4'b0, R[3:0]}; odd-byte writes store wrdata[3:0] only, upper nibble ignored and reads back 0.
- Reset:
  - pal_rddata, out_en, out_r/g/b, out_blank, out_hsync, out_vsync = 0.
  - Internal stage-1 valid = 0.
  - Palette RAM contents are not reset (undefined until written).
- Reset asserted mid-frame: pipeline valids clear immediately, outputs go 0. After release, the first out_en occurs 2 cycles after the first pix_en.
- CPU write:
  - Byte-lane write into the entry; takes effect at the clock edge with pal_write=1.
  - Entry is readable by either port from the following cycle.
- CPU read:
  - pal_rddata registered, 1-cycle latency; holds its value until the next pal_read.
  - pal_read and pal_write to the same byte in the same cycle: pal_rddata returns the OLD value.
- Pixel pipeline, fixed 2-cycle latency, advances every clk (pix_en is carried, not used as enable):
  - S1: RAM read of pix_idx registered; pix_en/blank/hsync/vsync registered alongside.
  - S2: output register.
    - out_r/g/b = S1 colour when S1 blank=0; forced 0 when S1 blank=1.
    - out_en/blank/hsync/vsync = S1 copies.
- Input/output alignment: input at edge N appears on outputs after edge N+2, for every signal, regardless of pix_en.
- Display/CPU collision (CPU write to entry E in the same cycle S1 reads E): the display gets the OLD colour; the new colour is used from the next read. No stall, no CPU wait state.
- Sync polarity untouched; module never generates sync.
- Index width: no truncation; all 2**INDEX_BITS entries addressable.

Optional Feature:
- Macro: PALETTE_MONO_EN.
- Defined: adds input port mono_en (1 bit).
  - When mono_en=1, S2 outputs out_r = out_g = out_b = Y, where Y = (5*R + 9*G + 2*B) >> 4 computed from the S1 colour.
  - Intermediate width 8 bits; max 240 >> 4 = 15, no saturation needed.
  - mono_en is sampled at S2 (not pipelined); blank still forces 0.
- Not defined: no mono_en port; colour always passed straight through.

Test Plan:
- Write addr 0x02=0xA5 and 0x03=0xF7, read 0x02 and 0x03 -> pal_rddata 0xA5, then 0x07.
- Program entry 1 = R3 G5 A; drive pix_en=1, pix_idx=1, blank=0 at cycle N -> at N+2: out_en=1, out_r=3, out_g=5, out_b=A.
- Same pixel with pix_blank=1 and hsync=1 -> out_r/g/b = 0, out_blank=1, out_hsync=1, both exactly 2 cycles later.
- Entry 7 = 0x111; on the cycle S1 reads idx 7, CPU writes 0x0E=0xFF -> that pixel out_g=1, out_b=1; next idx-7 pixel out_g=F, out_b=F.
- Assert rst_n=0 mid-line with pipeline full -> all outputs 0 immediately; release; first pix_en -> out_en 2 cycles later.
- PALETTE_MONO_EN build, mono_en=1, entry R=F G=F B=F -> out_r/g/b = F. Entry R=0 G=0 B=8 -> Y=1.

Source files
------------

// File: rtl/video_palette.sv
// Palette lookup stage: 8-bit colour index -> 12-bit RGB, 2-cycle registered pipeline.
// Optional PALETTE_MONO_EN adds a mono_en input selecting luma output.
module video_palette #(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS:0]   pal_addr,
    input  logic [7:0]            pal_wrdata,
    input  logic                  pal_write,
    input  logic                  pal_read,
    output logic [7:0]            pal_rddata,
    input  logic                  pix_en,
    input  logic [INDEX_BITS-1:0] pix_idx,
    input  logic                  pix_blank,
    input  logic                  pix_hsync,
    input  logic                  pix_vsync,
`ifdef PALETTE_MONO_EN
    input  logic                  mono_en,
`endif
    output logic                  out_en,
    output logic [3:0]            out_r,
    output logic [3:0]            out_g,
    output logic [3:0]            out_b,
    output logic                  out_blank,
    output logic                  out_hsync,
    output logic                  out_vsync
);
    localparam int DEPTH = 2**INDEX_BITS;

    // Split byte lanes: {G,B} in gb_mem, R nibble in r_mem.
    logic [7:0] gb_mem [DEPTH];
    logic [3:0] r_mem  [DEPTH];

    logic [INDEX_BITS-1:0] entry;
    assign entry = pal_addr[INDEX_BITS:1];

    always_ff @(posedge clk) begin
        if (pal_write) begin
            if (pal_addr[0]) r_mem[entry]  <= pal_wrdata[3:0];
            else             gb_mem[entry] <= pal_wrdata;
        end
    end

    logic [7:0] rddata_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rddata_q <= '0;
        else if (pal_read) rddata_q <= pal_addr[0] ? {4'h0, r_mem[entry]} : gb_mem[entry];
    end
    assign pal_rddata = rddata_q;

    // Stage 1: RAM read plus sideband; vld_pipe_q[1] is S1 valid, [2] is out_en.
    logic [2:1]  vld_pipe_q;
    logic        blank1_q, hs1_q, vs1_q;
    logic [11:0] col1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            blank1_q   <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            col1_q     <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], pix_en};
            blank1_q   <= pix_blank;
            hs1_q      <= pix_hsync;
            vs1_q      <= pix_vsync;
            col1_q     <= {r_mem[pix_idx], gb_mem[pix_idx]};
        end
    end

    logic [3:0] r_d, g_d, b_d;
`ifdef PALETTE_MONO_EN
    logic [7:0] luma_sum;
    logic [3:0] luma;
    always_comb begin
        luma_sum = {4'h0, col1_q[11:8]} * 8'd5 + {4'h0, col1_q[7:4]} * 8'd9
                 + {4'h0, col1_q[3:0]} * 8'd2;
        luma     = 4'(luma_sum >> 4);
        if (blank1_q) {r_d, g_d, b_d} = '0;
        else if (mono_en) {r_d, g_d, b_d} = {luma, luma, luma};
        else {r_d, g_d, b_d} = col1_q;
    end
`else
    always_comb begin
        if (blank1_q) {r_d, g_d, b_d} = '0;
        else          {r_d, g_d, b_d} = col1_q;
    end
`endif

    logic [3:0] r_q, g_q, b_q;
    logic       blank_q, hs_q, vs_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            blank_q <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            blank_q <= blank1_q;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
        end
    end

    assign out_en    = vld_pipe_q[2];
    assign out_r     = r_q;
    assign out_g     = g_q;
    assign out_b     = b_q;
    assign out_blank = blank_q;
    assign out_hsync = hs_q;
    assign out_vsync = vs_q;
endmodule
